// File: rtl/stereo_mem_arb.sv
// Round-robin arbiter that shares one memory command port between two
// camera write channels (W0, W1) and one display read channel (R).
// Each grant lasts at most BURST_LEN accepted beats, and there is always one
// idle cycle between grants.
module stereo_mem_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 29,
  parameter int BURST_LEN  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr0_en,
  input  logic [ADDR_WIDTH-1:0] wr0_addr,
  input  logic [DATA_WIDTH-1:0] wr0_data,
  output logic                  wr0_rdy,
  input  logic                  wr1_en,
  input  logic [ADDR_WIDTH-1:0] wr1_addr,
  input  logic [DATA_WIDTH-1:0] wr1_data,
  output logic                  wr1_rdy,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_rdy,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_valid,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_write,
  output logic                  mem_read,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rdata_valid,
  output logic [1:0]            grant
);

  localparam int BW = $clog2(BURST_LEN) + 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  // State encoding doubles as the grant code (0 none, 1 W0, 2 W1, 3 R).
  typedef enum logic [1:0] {
    ARB    = 2'd0,
    GNT_W0 = 2'd1,
    GNT_W1 = 2'd2,
    GNT_R  = 2'd3
  } state_t;

  state_t        state, state_nx;
  state_t        last, last_nx;   // last owner; only ever a GNT_* value
  logic [BW-1:0] beat, beat_nx;

  logic req0, req1, reqr;
  logic owner_req;

  // Frame buffer enables are active-low.
  assign req0 = ~wr0_en;
  assign req1 = ~wr1_en;
  assign reqr = ~rd_en;

  // State, last-owner pointer and beat counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB;
      last  <= GNT_W1;   // R comes first after reset
      beat  <= '0;
    end else begin
      state <= state_nx;
      last  <= last_nx;
      beat  <= beat_nx;
    end
  end

  // Next-state: cyclic search R -> W0 -> W1 starting after the last owner;
  // a grant ends on its final beat or when the owner drops its request.
  always_comb begin
    state_nx  = state;
    last_nx   = last;
    beat_nx   = beat;
    owner_req = 1'b0;
    case (state)
      GNT_W0: owner_req = req0;
      GNT_W1: owner_req = req1;
      GNT_R:  owner_req = reqr;
      default: owner_req = 1'b0;
    endcase

    if (state == ARB) begin
      beat_nx = '0;
      case (last)
        GNT_W1: begin
          if (reqr)      state_nx = GNT_R;
          else if (req0) state_nx = GNT_W0;
          else if (req1) state_nx = GNT_W1;
        end
        GNT_R: begin
          if (req0)      state_nx = GNT_W0;
          else if (req1) state_nx = GNT_W1;
          else if (reqr) state_nx = GNT_R;
        end
        default: begin
          if (req1)      state_nx = GNT_W1;
          else if (reqr) state_nx = GNT_R;
          else if (req0) state_nx = GNT_W0;
        end
      endcase
      if (state_nx != ARB) last_nx = state_nx;
    end else begin
      if (!owner_req) begin
        state_nx = ARB;
        beat_nx  = '0;
      end else if (mem_ready) begin
        if (beat == LAST_BEAT) begin
          state_nx = ARB;
          beat_nx  = '0;
        end else begin
          beat_nx = beat + 1'b1;
        end
      end
    end
  end

  // Owner mux onto the memory port, straight from the registered state so
  // the command stays stable while mem_ready is low.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    wr0_rdy   = 1'b0;
    wr1_rdy   = 1'b0;
    rd_rdy    = 1'b0;
    case (state)
      GNT_W0: begin
        mem_addr  = wr0_addr;
        mem_wdata = wr0_data;
        mem_write = req0;
        wr0_rdy   = req0 & mem_ready;
      end
      GNT_W1: begin
        mem_addr  = wr1_addr;
        mem_wdata = wr1_data;
        mem_write = req1;
        wr1_rdy   = req1 & mem_ready;
      end
      GNT_R: begin
        mem_addr  = rd_addr;
        mem_read  = reqr;
        rd_rdy    = reqr & mem_ready;
      end
      default: ;
    endcase
  end

  assign grant = state;

  // Read returns bypass arbitration entirely.
  assign rd_data       = mem_rdata;
  assign rd_data_valid = mem_rdata_valid;

endmodule

// File: tb/tb_stereo_mem_arb.sv
// Bench for stereo_mem_arb: directed scenarios then random traffic, every
// cycle compared against a transaction-level model of the arbitration rules.
module tb_stereo_mem_arb;
  localparam int DW = 32;
  localparam int AW = 29;
  localparam int BL = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr0_en, wr1_en, rd_en;
  logic [AW-1:0] wr0_addr, wr1_addr, rd_addr;
  logic [DW-1:0] wr0_data, wr1_data;
  logic          wr0_rdy, wr1_rdy, rd_rdy;
  logic [DW-1:0] rd_data;
  logic          rd_data_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_write, mem_read, mem_ready;
  logic [DW-1:0] mem_rdata;
  logic          mem_rdata_valid;
  logic [1:0]    grant;

  stereo_mem_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL)) dut (
    .clk(clk), .reset(reset),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_rdy(wr0_rdy),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_rdy(wr1_rdy),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_read(mem_read), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .mem_rdata_valid(mem_rdata_valid), .grant(grant)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  // Model state: owner/last use grant codes (0 none, 1 W0, 2 W1, 3 R).
  int m_owner, m_last, m_beats;

  // Snapshot of DUT outputs from the latest checked cycle.
  logic [1:0]    o_grant;
  logic          o_write, o_read, o_wr0_rdy, o_wr1_rdy, o_rd_rdy, o_rdv;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_wdata, o_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs at negedge against the model, then advance the
  // model with the inputs the DUT sampled at the posedge.
  task automatic cyc();
    logic rq[4];
    int   ring[3];
    int   idx, c;
    bit   found;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    rq[0] = 1'b0; rq[1] = !wr0_en; rq[2] = !wr1_en; rq[3] = !rd_en;
    @(negedge clk);
    o_grant = grant; o_write = mem_write; o_read = mem_read;
    o_wr0_rdy = wr0_rdy; o_wr1_rdy = wr1_rdy; o_rd_rdy = rd_rdy;
    o_rdv = rd_data_valid; o_addr = mem_addr; o_wdata = mem_wdata; o_rdata = rd_data;
    if (chk_en) begin
      e_addr  = (m_owner == 1) ? wr0_addr : (m_owner == 2) ? wr1_addr :
                (m_owner == 3) ? rd_addr : '0;
      e_wdata = (m_owner == 1) ? wr0_data : (m_owner == 2) ? wr1_data : '0;
      chk("grant", 64'(grant), 64'(m_owner));
      chk("mem_write", 64'(mem_write), 64'((m_owner == 1 || m_owner == 2) && rq[m_owner]));
      chk("mem_read", 64'(mem_read), 64'(m_owner == 3 && rq[3]));
      chk("mem_addr", 64'(mem_addr), 64'(e_addr));
      chk("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
      chk("wr0_rdy", 64'(wr0_rdy), 64'(m_owner == 1 && rq[1] && mem_ready));
      chk("wr1_rdy", 64'(wr1_rdy), 64'(m_owner == 2 && rq[2] && mem_ready));
      chk("rd_rdy", 64'(rd_rdy), 64'(m_owner == 3 && rq[3] && mem_ready));
      chk("rd_data_valid", 64'(rd_data_valid), 64'(mem_rdata_valid));
      chk("rd_data", 64'(rd_data), 64'(mem_rdata));
    end
    @(posedge clk);
    if (reset) begin
      m_owner = 0; m_last = 2; m_beats = 0;
    end else if (m_owner == 0) begin
      ring[0] = 3; ring[1] = 1; ring[2] = 2;
      idx = m_last % 3;
      found = 0;
      for (int k = 1; k <= 3; k++) begin
        c = ring[(idx + k) % 3];
        if (!found && rq[c]) begin
          found = 1; m_owner = c; m_last = c; m_beats = 0;
        end
      end
    end else if (!rq[m_owner]) begin
      m_owner = 0;
    end else if (mem_ready) begin
      m_beats++;
      if (m_beats == BL) m_owner = 0;
    end
    #1;
  endtask

  task automatic idle();
    wr0_en = 1'b1; wr1_en = 1'b1; rd_en = 1'b1;
    mem_ready = 1'b1; mem_rdata_valid = 1'b0; mem_rdata = '0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1; cyc(); reset = 1'b0;
  endtask

  initial begin
    int np, nr, nb, nbusy;
    logic [1:0] g[16];
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_data;
    bit done;
    logic [1:0] prev;
    int seq[$];
    int exp_seq[7];
    int tmp;

    reset = 1'b1; idle();
    wr0_addr = '0; wr1_addr = '0; rd_addr = '0; wr0_data = '0; wr1_data = '0;
    repeat (2) @(posedge clk);
    #1;
    m_owner = 0; m_last = 2; m_beats = 0;
    chk_en = 1;

    // Reset with everyone requesting: idle during reset, R first afterwards.
    wr0_en = 0; wr1_en = 0; rd_en = 0;
    reset = 1'b1;
    cyc(); cyc();
    chk("rst_grant", 64'(o_grant), 64'd0);
    chk("rst_cmd", 64'({o_write, o_read}), 64'd0);
    reset = 1'b0;
    cyc();
    cyc();
    chk("rst_first_r", 64'(o_grant), 64'd3);

    // Full quantum for a lone W0: 8 beats at 2..9, bubble, re-grant.
    idle(); pulse_reset();
    wr0_en = 0; np = 0;
    for (int i = 0; i < 11; i++) begin
      wr0_addr = AW'(2 + np); wr0_data = DW'(32'hA000 + np);
      cyc();
      g[i] = o_grant;
      if (o_wr0_rdy) begin
        chk("fq_addr", 64'(o_addr), 64'(2 + np));
        np++;
      end
      if (i == 8) chk("fq_beats", 64'(np), 64'd8);
    end
    chk("fq_g0", 64'(g[0]), 64'd0);
    chk("fq_g1", 64'(g[1]), 64'd1);
    chk("fq_g8", 64'(g[8]), 64'd1);
    chk("fq_bubble", 64'(g[9]), 64'd0);
    chk("fq_regrant", 64'(g[10]), 64'd1);

    // Round-robin with all three requesting.
    idle(); pulse_reset();
    wr0_en = 0; wr1_en = 0; rd_en = 0;
    prev = 2'd0; nbusy = 0; seq.delete();
    for (int i = 0; i < 60 && seq.size() < 7; i++) begin
      cyc();
      if (o_grant != 2'd0) nbusy++;
      if (o_grant != prev) seq.push_back(int'(o_grant));
      prev = o_grant;
    end
    exp_seq = '{3, 0, 1, 0, 2, 0, 3};
    chk("rr_len", 64'(seq.size()), 64'd7);
    for (int i = 0; i < 7 && i < seq.size(); i++) chk("rr_seq", 64'(seq[i]), 64'(exp_seq[i]));
    chk("rr_busy", 64'(nbusy), 64'd25);

    // Backpressure on W1: 5 stall cycles after 3 beats.
    idle(); pulse_reset();
    wr1_en = 0; nb = 0; done = 0; h_addr = '0; h_data = '0;
    for (int i = 0; i < 16; i++) begin
      wr1_addr = AW'(100 + nb); wr1_data = DW'(32'hD0 + nb);
      mem_ready = !(i >= 4 && i < 9);
      cyc();
      if (i == 4) begin h_addr = o_addr; h_data = o_wdata; end
      if (i > 4 && i < 9) begin
        chk("bp_addr", 64'(o_addr), 64'(h_addr));
        chk("bp_wdata", 64'(o_wdata), 64'(h_data));
        chk("bp_rdy", 64'(o_wr1_rdy), 64'd0);
      end
      if (o_grant == 2'd0 && nb > 0) done = 1;
      if (!done && o_wr1_rdy) nb++;
    end
    chk("bp_beats", 64'(nb), 64'd8);

    // Early release by R after 3 beats, then W0, with a read return mid-W0.
    idle(); pulse_reset();
    rd_en = 0; wr0_en = 0; nr = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 7) begin mem_rdata = 32'h1234ABCD; mem_rdata_valid = 1'b1; end
      else begin mem_rdata_valid = 1'b0; end
      cyc();
      g[i] = o_grant;
      if (o_rd_rdy) nr++;
      if (nr == 3) rd_en = 1;
      if (i == 7) begin
        chk("ret_valid", 64'(o_rdv), 64'd1);
        chk("ret_data", 64'(o_rdata), 64'h1234ABCD);
        chk("ret_grant_w0", 64'(o_grant), 64'd1);
      end
    end
    chk("er_beats", 64'(nr), 64'd3);
    chk("er_g4", 64'(g[4]), 64'd3);
    chk("er_bubble", 64'(g[5]), 64'd0);
    chk("er_w0", 64'(g[6]), 64'd1);
    mem_rdata_valid = 1'b0;

    // Reset in the middle of a W1 burst; R wins afterwards.
    idle(); pulse_reset();
    wr1_en = 0;
    repeat (5) cyc();
    chk("mb_w1", 64'(o_grant), 64'd2);
    reset = 1'b1; rd_en = 0;
    cyc();
    reset = 1'b0;
    cyc();
    chk("mb_grant", 64'(o_grant), 64'd0);
    chk("mb_write", 64'(o_write), 64'd0);
    cyc();
    chk("mb_r_first", 64'(o_grant), 64'd3);

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      wr0_en = ($urandom_range(0, 3) == 0);
      wr1_en = ($urandom_range(0, 3) == 0);
      rd_en  = ($urandom_range(0, 3) == 0);
      mem_ready = ($urandom_range(0, 3) != 0);
      tmp = int'($urandom); wr0_addr = AW'(tmp);
      tmp = int'($urandom); wr1_addr = AW'(tmp);
      tmp = int'($urandom); rd_addr  = AW'(tmp);
      wr0_data = $urandom; wr1_data = $urandom; mem_rdata = $urandom;
      mem_rdata_valid = ($urandom_range(0, 1) == 1);
      reset = ($urandom_range(0, 199) == 0);
      cyc();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
